// File: rtl/demux_pkg.sv
// Shared types and constants for the buffered 1:4 demultiplexer.
// Lane count and the per-lane FIFO depth are fixed by the design.
package demux_pkg;

  localparam int LANES      = 4;
  localparam int LANE_DEPTH = 2;

  typedef logic [1:0] lane_sel_t;
  typedef logic [1:0] lane_cnt_t;

  localparam lane_cnt_t LANE_FULL = lane_cnt_t'(LANE_DEPTH);

endpackage

// File: rtl/demux_lane_fifo.sv
// Two-entry lane FIFO with 1-bit wrapping pointers and an occupancy count.
// The head word is read straight from storage and is forced to zero while the lane is empty.
module demux_lane_fifo
  import demux_pkg::*;
#(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [N-1:0] din,
  input  logic         pop,
  output logic [N-1:0] dout,
  output logic         valid,
  output lane_cnt_t    count
);

  logic [N-1:0] mem [LANE_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push && (count != LANE_FULL);
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Push and pop together leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != '0);
  assign dout  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/demux_nto4n_buf.sv
// Registered 1:4 demultiplexer: routes I to the lane chosen by S, each lane buffered by its own FIFO.
// in_ready looks only at the selected lane's occupancy, never at the consumer's ready.
module demux_nto4n_buf
  import demux_pkg::*;
#(
  parameter int N     = 24,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N-1:0]       I,
  input  lane_sel_t          S,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N-1:0]       O0,
  output logic [N-1:0]       O1,
  output logic [N-1:0]       O2,
  output logic [N-1:0]       O3,
  output logic [LANES-1:0]   valid,
  input  logic [LANES-1:0]   ready,
  output logic [2*LANES-1:0] count
);

  lane_cnt_t        lane_cnt  [LANES];
  logic [N-1:0]     lane_dout [LANES];
  logic [LANES-1:0] push;

  assign in_ready = rst && en && (lane_cnt[S] != lane_cnt_t'(DEPTH));

  always_comb begin
    push    = '0;
    push[S] = in_valid && in_ready;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane_fifo #(.N(N)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .din   (I),
      .pop   (ready[k]),
      .dout  (lane_dout[k]),
      .valid (valid[k]),
      .count (lane_cnt[k])
    );
    assign count[2*k +: 2] = lane_cnt[k];
  end

  assign O0 = lane_dout[0];
  assign O1 = lane_dout[1];
  assign O2 = lane_dout[2];
  assign O3 = lane_dout[3];

endmodule

// File: tb/tb_demux_nto4n_buf.sv
// Bench for demux_nto4n_buf: directed scenarios then random traffic,
// checked every cycle against four word queues standing for the lanes.
module tb_demux_nto4n_buf;

  localparam int N = 24;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] I;
  logic [1:0]   S;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] O0, O1, O2, O3;
  logic [3:0]   valid;
  logic [3:0]   ready;
  logic [7:0]   count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [N-1:0] q [4][$];

  always #5 clk = ~clk;

  demux_nto4n_buf #(.N(N), .DEPTH(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .I        (I),
    .S        (S),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .O0       (O0),
    .O1       (O1),
    .O2       (O2),
    .O3       (O3),
    .valid    (valid),
    .ready    (ready),
    .count    (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [N-1:0] dut_o(input int k);
    case (k)
      0: return O0;
      1: return O1;
      2: return O2;
      default: return O3;
    endcase
  endfunction

  task automatic check_state(input string ctx);
    for (int k = 0; k < 4; k++) begin
      logic [N-1:0] exp_o;
      exp_o = (q[k].size() > 0) ? q[k][0] : '0;
      chk($sformatf("%s_valid%0d", ctx, k), 32'(valid[k]), 32'(q[k].size() > 0));
      chk($sformatf("%s_count%0d", ctx, k), 32'(count[2*k +: 2]), 32'(q[k].size()));
      chk($sformatf("%s_O%0d", ctx, k), 32'(dut_o(k)), 32'(exp_o));
    end
  endtask

  // One clock cycle: drive, check current state and in_ready, clock, advance the model.
  task automatic step(input logic r, input logic e, input logic v, input logic [1:0] s,
                      input logic [N-1:0] d, input logic [3:0] rd, input string ctx);
    logic exp_rdy;
    rst = r; en = e; in_valid = v; S = s; I = d; ready = rd;
    #1;
    exp_rdy = r && e && (q[s].size() < 2);
    chk({ctx, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
    check_state(ctx);
    @(posedge clk);
    if (!r) begin
      for (int k = 0; k < 4; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 4; k++)
        if (rd[k] && q[k].size() > 0) void'(q[k].pop_front());
      if (v && exp_rdy) q[s].push_back(d);
    end
    #1;
  endtask

  initial begin
    logic         r, e, v, held;
    logic [1:0]   s, hs;
    logic [N-1:0] d, hd;
    logic [3:0]   rd;

    rst = 1'b0; en = 1'b1; in_valid = 1'b0; S = '0; I = '0; ready = '0;
    @(posedge clk);
    #1;

    // Reset held for two cycles while the producer offers a word.
    step(0, 1, 1, 2'd1, 24'h123456, 4'b0000, "reset");
    step(0, 1, 1, 2'd1, 24'h123456, 4'b0000, "reset");
    chk("reset_valid_all", 32'(valid), 32'h0);
    chk("reset_count_all", 32'(count), 32'h0);
    step(1, 1, 0, 2'd0, 24'h0, 4'b0000, "post_reset");

    // Single route to lane 2.
    step(1, 1, 1, 2'd2, 24'hABCDEF, 4'b0000, "route");
    chk("route_valid_vec", 32'(valid), 32'h4);
    chk("route_O2", 32'(O2), 32'hABCDEF);
    chk("route_count2", 32'(count[5:4]), 32'd1);
    chk("route_O0", 32'(O0), 32'h0);
    step(1, 1, 0, 2'd0, 24'h0, 4'b0100, "route_drain");

    // Backpressure on lane 1.
    step(1, 1, 1, 2'd1, 24'h000111, 4'b0000, "bp_w1");
    step(1, 1, 1, 2'd1, 24'h000222, 4'b0000, "bp_w2");
    step(1, 1, 1, 2'd1, 24'h000333, 4'b0000, "bp_w3_blocked");
    chk("bp_full_in_ready", 32'(in_ready), 32'h0);
    chk("bp_full_count1", 32'(count[3:2]), 32'd2);
    step(1, 1, 1, 2'd1, 24'h000333, 4'b0010, "bp_pop_full");
    chk("bp_after_pop_O1", 32'(O1), 32'h000222);
    step(1, 1, 1, 2'd1, 24'h000333, 4'b0010, "bp_w3_accept");
    chk("bp_w3_O1", 32'(O1), 32'h000333);
    for (int i = 0; i < 2; i++) step(1, 1, 0, 2'd0, 24'h0, 4'b0010, "bp_drain");

    // Lane 0 full and stalled; lane 3 still accepts.
    step(1, 1, 1, 2'd0, 24'h00AA01, 4'b0000, "iso_fill");
    step(1, 1, 1, 2'd0, 24'h00AA02, 4'b0000, "iso_fill");
    step(1, 1, 1, 2'd3, 24'h000011, 4'b0000, "iso_lane3");
    chk("iso_O3", 32'(O3), 32'h000011);
    chk("iso_count0", 32'(count[1:0]), 32'd2);
    chk("iso_O0", 32'(O0), 32'h00AA01);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 2'd0, 24'h0, 4'b1111, "iso_drain");

    // Streaming through lane 0 at one word per cycle.
    for (int w = 1; w <= 8; w++) step(1, 1, 1, 2'd0, N'(w), 4'b0001, "thru");
    chk("thru_count0", 32'(count[1:0]), 32'd1);
    chk("thru_O0", 32'(O0), 32'd8);
    step(1, 1, 0, 2'd0, 24'h0, 4'b0001, "thru_drain");

    // en dropped mid-traffic, then a one-cycle reset.
    step(1, 1, 1, 2'd0, 24'h0C0001, 4'b0000, "en_fill");
    step(1, 1, 1, 2'd0, 24'h0C0002, 4'b0000, "en_fill");
    step(1, 1, 1, 2'd2, 24'h0C2001, 4'b0000, "en_fill");
    step(1, 1, 1, 2'd2, 24'h0C2002, 4'b0000, "en_fill");
    step(1, 0, 1, 2'd1, 24'h0C1001, 4'b0101, "en_off");
    chk("en_off_count", 32'(count), 32'h11);
    step(1, 0, 1, 2'd1, 24'h0C1001, 4'b0000, "en_off_hold");
    step(1, 0, 1, 2'd3, 24'h0C3001, 4'b0000, "en_off_hold");
    step(0, 1, 1, 2'd0, 24'h0C0003, 4'b0000, "mid_reset");
    chk("mid_reset_valid", 32'(valid), 32'h0);
    step(1, 1, 0, 2'd0, 24'h0, 4'b0000, "post_mid_reset");

    // Random traffic; the producer holds I/S while stalled.
    held = 1'b0; hs = '0; hd = '0;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) != 0);
      e  = ($urandom_range(0, 7) != 0);
      rd = 4'($urandom);
      if (held) begin
        v = 1'b1; s = hs; d = hd;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        s = 2'($urandom_range(0, 3));
        d = N'($urandom);
      end
      held = r && v && !(e && q[s].size() < 2);
      hs = s; hd = d;
      step(r, e, v, s, d, rd, "rand");
    end
    check_state("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
